// File: rtl/stream_packet_transformer_if.sv
// Byte-enabled valid/ready stream bundle for stream_packet_transformer.
// master drives the input side and out_ready; slave is the transformer.
interface stream_packet_transformer_if #(
  parameter int W = 32
);
  localparam int NB = W / 8;

  logic [W-1:0]  in_data;
  logic [NB-1:0] in_byte_en;
  logic          in_end;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [NB-1:0] out_byte_en;
  logic          out_end;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_data, in_byte_en, in_end, in_valid,
    input  in_ready,
    input  out_data, out_byte_en, out_end, out_valid,
    output out_ready
  );

  modport slave (
    input  in_data, in_byte_en, in_end, in_valid,
    output in_ready,
    output out_data, out_byte_en, out_end, out_valid,
    input  out_ready
  );
endinterface

// File: rtl/stream_packet_transformer.sv
// Per-packet stream transform with output register plus skid buffer.
// Define STREAM_XFORM_SAT_EN to make the add mode saturate instead of wrap.
module stream_packet_transformer #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int ROT_W          = $clog2(DATA_BUS_WIDTH),
  parameter int CNT_W          = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  stream_packet_transformer_if.slave s,
  input  logic [2:0]                ctrl_sel,
  input  logic [DATA_BUS_WIDTH-1:0] increment_val,
  input  logic [DATA_BUS_WIDTH-1:0] xor_mask,
  input  logic [ROT_W-1:0]          rot_amt,
  output logic [CNT_W-1:0]          pkt_count
);
  localparam int W  = DATA_BUS_WIDTH;
  localparam int NB = W / 8;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [NB-1:0] be;
    logic          last;
  } beat_t;

  logic             first_q;
  logic [2:0]       mode_q;
  logic [W-1:0]     inc_q;
  logic [W-1:0]     xm_q;
  logic [ROT_W-1:0] rot_q;

  logic [2:0]       mode;
  logic [W-1:0]     inc;
  logic [W-1:0]     xm;
  logic [ROT_W-1:0] rot;

  beat_t or_q, sr_q, or_n, sr_n, nb;
  logic  or_v, sr_v, or_vn, sr_vn, rdy_q;
  logic  accept, fire, or_free;

  logic [W-1:0]   m;
  logic [W-1:0]   r;
  logic [NB-1:0]  obe;
  logic [2*W-1:0] dbl;
`ifdef STREAM_XFORM_SAT_EN
  logic [W:0]     sum;
`endif

  // first beat of a packet uses live controls
  assign mode = first_q ? ctrl_sel      : mode_q;
  assign inc  = first_q ? increment_val : inc_q;
  assign xm   = first_q ? xor_mask      : xm_q;
  assign rot  = first_q ? rot_amt       : rot_q;

  assign accept  = s.in_valid & rdy_q;
  assign fire    = or_v & s.out_ready;
  assign or_free = ~or_v | s.out_ready;

  assign s.in_ready    = rdy_q;
  assign s.out_valid   = or_v;
  assign s.out_data    = or_q.data;
  assign s.out_byte_en = or_q.be;
  assign s.out_end     = or_q.last;

  // mask, transform and post-mask the incoming beat
  always_comb begin
    m   = '0;
    r   = '0;
    obe = s.in_byte_en;
    dbl = '0;
`ifdef STREAM_XFORM_SAT_EN
    sum = '0;
`endif
    for (int i = 0; i < NB; i++)
      m[8*i+:8] = s.in_byte_en[i] ? s.in_data[8*i+:8] : 8'h00;
    dbl = {m, m} << rot;
    unique case (1'b1)
      (mode == 3'd1): r = ~m;
      (mode == 3'd2): begin
`ifdef STREAM_XFORM_SAT_EN
        sum = {1'b0, m} + {1'b0, inc};
        r   = sum[W] ? '1 : sum[W-1:0];
`else
        r = m + inc;
`endif
      end
      (mode == 3'd3): begin
        for (int i = 0; i < NB; i++) begin
          r[8*i+:8] = m[8*(NB-1-i)+:8];
          obe[i]    = s.in_byte_en[NB-1-i];
        end
      end
      (mode == 3'd4): r = m ^ xm;
      (mode == 3'd5): r = dbl[2*W-1:W];
      default:        r = m;
    endcase
    for (int i = 0; i < NB; i++)
      if (!obe[i]) r[8*i+:8] = 8'h00;
    nb.data = r;
    nb.be   = obe;
    nb.last = s.in_end;
  end

  // output register refills from skid first, then from input
  always_comb begin
    or_n  = or_q;
    or_vn = or_v;
    sr_n  = sr_q;
    sr_vn = sr_v;
    if (or_free) begin
      if (sr_v) begin
        or_n  = sr_q;
        or_vn = 1'b1;
        sr_vn = 1'b0;
      end else if (accept) begin
        or_n  = nb;
        or_vn = 1'b1;
      end else begin
        or_vn = 1'b0;
      end
    end else if (accept) begin
      sr_n  = nb;
      sr_vn = 1'b1;
    end
  end

  // buffer state and ready flop
  always_ff @(posedge clock) begin
    if (reset) begin
      or_q  <= '0;
      sr_q  <= '0;
      or_v  <= 1'b0;
      sr_v  <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      or_q  <= or_n;
      sr_q  <= sr_n;
      or_v  <= or_vn;
      sr_v  <= sr_vn;
      rdy_q <= ~sr_vn;
    end
  end

  // first-beat flag and per-packet control latch
  always_ff @(posedge clock) begin
    if (reset) begin
      first_q <= 1'b1;
      mode_q  <= '0;
      inc_q   <= '0;
      xm_q    <= '0;
      rot_q   <= '0;
    end else if (accept) begin
      first_q <= s.in_end;
      if (first_q) begin
        mode_q <= ctrl_sel;
        inc_q  <= increment_val;
        xm_q   <= xor_mask;
        rot_q  <= rot_amt;
      end
    end
  end

  // completed packets leaving the block
  always_ff @(posedge clock) begin
    if (reset)
      pkt_count <= '0;
    else if (fire && or_q.last)
      pkt_count <= pkt_count + 1'b1;
  end
endmodule

// File: tb/tb_stream_packet_transformer.sv
// Scoreboard bench for stream_packet_transformer.
// Expected beats are queued at input accept and popped at output handshake.
module tb_stream_packet_transformer;
  localparam int W  = 32;
  localparam int NB = W / 8;
  localparam int RW = $clog2(W);
  localparam int CW = 16;
`ifdef STREAM_XFORM_SAT_EN
  localparam logic [W-1:0] SAT_EXP = 32'hFFFFFFFF;
`else
  localparam logic [W-1:0] SAT_EXP = 32'hFFFFFFFE;
`endif

  typedef struct packed {
    logic [W-1:0]  d;
    logic [NB-1:0] be;
    logic          e;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    ctrl_sel = '0;
  logic [W-1:0]  increment_val = '0;
  logic [W-1:0]  xor_mask = '0;
  logic [RW-1:0] rot_amt = '0;
  logic [CW-1:0] pkt_count;

  stream_packet_transformer_if #(.W(W)) ifc ();

  stream_packet_transformer #(
    .DATA_BUS_WIDTH(W),
    .ROT_W(RW),
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .s(ifc),
    .ctrl_sel(ctrl_sel),
    .increment_val(increment_val),
    .xor_mask(xor_mask),
    .rot_amt(rot_amt),
    .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  beat_t         q[$];
  beat_t         mx;
  beat_t         st_b;
  bit            st_v = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            pkt_exp = 0;
  bit            first_m = 1;
  bit            done = 0;
  logic [2:0]    lsel;
  logic [W-1:0]  linc, lmsk;
  logic [RW-1:0] lrot;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t model(
    input logic [W-1:0] d, input logic [NB-1:0] be, input logic e,
    input logic [2:0] sel, input logic [W-1:0] inc,
    input logic [W-1:0] msk, input logic [RW-1:0] rot);
    logic [7:0]    b [NB];
    logic [NB-1:0] ob;
    logic [W-1:0]  mw, rw;
    logic [W:0]    sm;
    beat_t         res;
    mw = '0;
    for (int i = 0; i < NB; i++) begin
      b[i] = be[i] ? d[8*i+:8] : 8'h00;
      mw[8*i+:8] = b[i];
    end
    ob = be;
    rw = mw;
    case (sel)
      3'd1: rw = ~mw;
      3'd2: begin
        sm = {1'b0, mw} + {1'b0, inc};
        rw = sm[W-1:0];
`ifdef STREAM_XFORM_SAT_EN
        if (sm[W]) rw = '1;
`endif
      end
      3'd3: for (int i = 0; i < NB; i++) begin
        rw[8*i+:8] = b[NB-1-i];
        ob[i] = be[NB-1-i];
      end
      3'd4: rw = mw ^ msk;
      3'd5: rw = (rot == 0) ? mw : ((mw << rot) | (mw >> (W - int'(rot))));
      default: ;
    endcase
    for (int i = 0; i < NB; i++)
      if (!ob[i]) rw[8*i+:8] = 8'h00;
    res.d = rw;
    res.be = ob;
    res.e = e;
    return res;
  endfunction

  task automatic send(
    input logic [W-1:0] d, input logic [NB-1:0] be, input logic e,
    input logic [2:0] sel, input logic [W-1:0] inc,
    input logic [W-1:0] msk, input logic [RW-1:0] rot,
    input bit kx, input logic [W-1:0] kd, input logic [NB-1:0] kbe);
    int    t;
    beat_t x;
    ifc.in_data = d;
    ifc.in_byte_en = be;
    ifc.in_end = e;
    ifc.in_valid = 1'b1;
    ctrl_sel = sel;
    increment_val = inc;
    xor_mask = msk;
    rot_amt = rot;
    t = 0;
    forever begin
      @(negedge clock);
      if (ifc.in_ready) break;
      t++;
      if (t > 200) begin
        chk("in_ready_timeout", ifc.in_ready, 1);
        ifc.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clock);
    if (first_m) begin
      lsel = sel;
      linc = inc;
      lmsk = msk;
      lrot = rot;
    end
    x = model(d, be, e, lsel, linc, lmsk, lrot);
    if (kx) begin
      x.d = kd;
      x.be = kbe;
    end
    q.push_back(x);
    first_m = e;
    #1;
  endtask

  task automatic idle();
    ifc.in_valid = 1'b0;
    ifc.in_end = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    ifc.out_ready = 1'b1;
    while ((q.size() != 0 || ifc.out_valid) && t < 100) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  // output monitor: stability, pkt_count and scoreboard pop
  always @(negedge clock) begin
    if (reset) begin
      st_v = 0;
    end else begin
      chk("pkt_count", pkt_count, CW'(pkt_exp));
      if (st_v) begin
        chk("stall_data", ifc.out_data, st_b.d);
        chk("stall_be", ifc.out_byte_en, st_b.be);
        chk("stall_end", ifc.out_end, st_b.e);
      end
      st_v = ifc.out_valid && !ifc.out_ready;
      st_b.d = ifc.out_data;
      st_b.be = ifc.out_byte_en;
      st_b.e = ifc.out_end;
      if (ifc.out_valid && ifc.out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected", 1, 0);
        end else begin
          mx = q.pop_front();
          chk("out_data", ifc.out_data, mx.d);
          chk("out_be", ifc.out_byte_en, mx.be);
          chk("out_end", ifc.out_end, mx.e);
          if (mx.e) pkt_exp++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data = '0;
    ifc.in_byte_en = '0;
    ifc.in_end = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_data", ifc.out_data, 0);
    chk("rst_out_be", ifc.out_byte_en, 0);
    chk("rst_out_end", ifc.out_end, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_in_ready", ifc.in_ready, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("ready_after_rst", ifc.in_ready, 1);

    send(32'h12345678, 4'hF, 1, 0, 5, 32'hFF00FF00, 0, 1, 32'h12345678, 4'hF);
    chk("lat_m0", ifc.out_valid, 1);
    send(32'h12345678, 4'hF, 1, 1, 5, 32'hFF00FF00, 0, 1, 32'hEDCBA987, 4'hF);
    chk("lat_m1", ifc.out_valid, 1);
    send(32'h12345678, 4'hF, 1, 2, 5, 32'hFF00FF00, 0, 1, 32'h1234567D, 4'hF);
    chk("lat_m2", ifc.out_valid, 1);
    send(32'h12345678, 4'hF, 1, 4, 5, 32'hFF00FF00, 0, 1, 32'hED34A978, 4'hF);
    chk("lat_m4", ifc.out_valid, 1);
    idle();
    repeat (2) @(posedge clock);
    #1;
    chk("pkt_after_4", pkt_count, 4);

    send(32'hFFFFFFFF, 4'hF, 1, 2, 32'hFFFFFFFF, 0, 0, 1, SAT_EXP, 4'hF);
    send(32'hAABBCCDD, 4'b1100, 1, 3, 0, 0, 0, 1, 32'h0000BBAA, 4'b0011);
    send(32'h12345678, 4'hF, 1, 5, 0, 0, 8, 1, 32'h34567812, 4'hF);
    send(32'h11223344, 4'hF, 0, 4, 0, 32'h0F0F0F0F, 0, 1, 32'h1E2D3C4B, 4'hF);
    send(32'h55667788, 4'hF, 0, 0, 0, 32'h0F0F0F0F, 0, 1, 32'h5A697887, 4'hF);
    send(32'h99AABBCC, 4'hF, 1, 0, 0, 32'h0F0F0F0F, 0, 1, 32'h96A5B4C3, 4'hF);
    send(32'hDEADBEEF, 4'hF, 1, 0, 0, 32'h0F0F0F0F, 0, 1, 32'hDEADBEEF, 4'hF);
    idle();
    drain();

    fork
      begin
        for (int k = 0; k < 6; k++)
          send(32'h01020304 * (k + 1), 4'hF, k == 5, 4, 0,
               32'hA5A5A5A5, 0, 0, 0, 0);
        idle();
      end
      begin
        repeat (2) @(posedge clock);
        #1 ifc.out_ready = 1'b0;
        @(posedge clock);
        #1 chk("bp_in_ready_drop", ifc.in_ready, 0);
        repeat (2) @(posedge clock);
        #1 ifc.out_ready = 1'b1;
        chk("bp_in_ready_held", ifc.in_ready, 0);
        @(posedge clock);
        #1 chk("bp_in_ready_rise", ifc.in_ready, 1);
      end
    join
    drain();

    ifc.out_ready = 1'b0;
    send(32'hCAFEF00D, 4'hF, 0, 1, 0, 0, 0, 0, 0, 0);
    send(32'hBAADF00D, 4'hF, 0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    reset = 1'b1;
    q.delete();
    first_m = 1;
    pkt_exp = 0;
    @(posedge clock);
    #1;
    chk("mid_rst_out_valid", ifc.out_valid, 0);
    chk("mid_rst_in_ready", ifc.in_ready, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    ifc.out_ready = 1'b1;
    chk("post_rst_out_valid", ifc.out_valid, 0);
    chk("post_rst_pkt", pkt_count, 0);
    @(posedge clock);
    #1;
    chk("post_rst_in_ready", ifc.in_ready, 1);
    chk("post_rst_no_ghost", ifc.out_valid, 0);
    send(32'h0000FFFF, 4'hF, 1, 4, 0, 32'hFFFFFFFF, 0, 1, 32'hFFFF0000, 4'hF);
    idle();
    drain();
    chk("post_rst_pkt_one", pkt_count, 1);

    done = 0;
    fork
      begin
        for (int k = 0; k < 40; k++)
          send($urandom, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0) || (k == 39),
               3'($urandom_range(0, 7)), $urandom, $urandom,
               RW'($urandom_range(0, W - 1)), 0, 0, 0);
        idle();
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1 ifc.out_ready = ($urandom_range(0, 3) != 0);
        end
        ifc.out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stream_packet_transformer.md
# stream_packet_transformer

Parametrised successor to the single-word stream manipulator. It sits in the same valid/ready byte-enabled stream path and applies one of eight per-packet transforms. Improvements: configurable bus width, a registered output with a skid buffer for full throughput under backpressure, mode and operand latching per packet, byte-enable-aware arithmetic and a completed-packet counter.

## Interface
- DATA_BUS_WIDTH, 32, stream data width in bits; multiple of 8, ≥16
- ROT_W, $clog2(DATA_BUS_WIDTH), width of rot_amt
- CNT_W, 16, width of pkt_count

- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_BUS_WIDTH  input beat data
- in_byte_en  in  DATA_BUS_WIDTH/8  input byte enables, bit i ↔ byte i
- in_end  in  1  last beat of packet
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- out_data  out  DATA_BUS_WIDTH  transformed data
- out_byte_en  out  DATA_BUS_WIDTH/8  output byte enables
- out_end  out  1  last beat of packet
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- ctrl_sel  in  3  transform mode, sampled at first beat of packet
- increment_val  in  DATA_BUS_WIDTH  add operand, sampled with ctrl_sel
- xor_mask  in  DATA_BUS_WIDTH  XOR operand, sampled with ctrl_sel
- rot_amt  in  ROT_W  rotate-left amount, sampled with ctrl_sel
- pkt_count  out  CNT_W  packets completed on output

## Operation
- Input handshake: in_valid & in_ready. Output handshake: out_valid & out_ready.
- First-beat flag: set by reset and by every accepted in_end beat. On an accepted beat with the flag set, ctrl_sel, increment_val, xor_mask and rot_amt are latched and used for every beat up to and including in_end. A single-beat packet uses the live values.
- Pre-mask: bytes with in_byte_en=0 are forced to 0 before the transform.
- Modes on the masked word m:
  - 0: pass
  - 1: ~m
  - 2: m + increment_val, modulo 2^W, carries cross byte lanes
  - 3: byte reverse; byte_en is reversed too
  - 4: m ^ xor_mask
  - 5: rotate left by rot_amt
  - 6, 7: reserved; behave as pass
- Post-mask: output bytes whose out_byte_en bit is 0 are driven 0.
- out_end and out_byte_en are forwarded with their beat. Modes never reorder, drop or merge beats.
- pkt_count increments on each output handshake with out_end=1 and wraps at 2^CNT_W.

## Timing
- Reset values: out_valid=0, out_data=0, out_byte_en=0, out_end=0, pkt_count=0, in_ready=0 while reset is high and 1 in the first cycle after.
- Buffering: one output register (OR) plus one skid register (SR). in_ready = ~SR_valid, taken directly from a flop.
- Latency: a beat accepted in cycle N is on out_* in cycle N+1 if OR was free or drained in cycle N.
- Throughput: 1 beat/cycle when out_ready is held high.
- out_ready low with OR full: the next accepted beat goes to SR and in_ready falls the following cycle. When out_ready returns, OR takes SR and in_ready rises one cycle later. No beat is lost or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_* must hold stable.
- Reset mid-packet: all beats in OR and SR are discarded, the first-beat flag is set, and pkt_count is cleared. The remaining input beats of the interrupted packet are treated as a new packet.
- Simultaneous input and output handshake with OR full and SR empty: OR reloads from the new beat; SR stays empty.

## Configuration
- STREAM_XFORM_SAT_EN defined: mode 2 saturates. An unsigned overflow of the W-bit sum yields all-ones before post-mask.
- Not defined: mode 2 wraps modulo 2^W.
- All other modes are unaffected either way.

## Test plan
- Mode 0/1/2/4, one-beat packets, data 0x12345678, inc=5, mask=0xFF00FF00 -> out 0x12345678, 0xEDCBA987, 0x1234567D, 0xED34A978, each one cycle after accept; pkt_count 1→4.
- Mode 2, data 0xFFFFFFFF, inc=0xFFFFFFFF -> 0xFFFFFFFE without the macro, 0xFFFFFFFF with STREAM_XFORM_SAT_EN.
- Mode 3, data 0xAABBCCDD, byte_en 4'b1100 -> out_data 0x0000BBAA, out_byte_en 4'b0011. Mode 5, rot=8, data 0x12345678 -> 0x34567812.
- 3-beat packet in mode 4 with ctrl_sel changed to 0 after beat 1 -> all 3 beats XORed; the next packet uses mode 0.
- Continuous input, out_ready low for 3 cycles -> in_ready drops one cycle after SR fills. Output order, data and out_end are exact, and out_* stay stable while stalled.
- reset pulsed 2 cycles mid-packet with 2 beats buffered -> out_valid=0 and pkt_count=0 the next cycle, buffered beats never appear, and the next beat latches a fresh mode.
